// File: rtl/req_ack_responder.sv
// Responder end of a 4-phase req/ack handshake: captures req_data, raises ack
// after ACK_DELAY wait edges, and queues each accepted word for a valid/ready consumer.
module req_ack_responder #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int ACK_DELAY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    input  logic [DATA_W-1:0]      req_data,
    output logic                   ack,
    output logic                   rsp_valid,
    output logic [DATA_W-1:0]      rsp_data,
    input  logic                   rsp_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   proto_err,
    output logic [1:0]             state
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_ACK  = 2'b10,
        S_BAD  = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic              ack_d;
    logic              proto_err_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [1:0]        dly_q, dly_d;
    logic              push, pop;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    // Downstream handshake: a word transfers on every posedge where
    // rsp_valid && rsp_ready; rsp_valid never depends on rsp_ready, and the
    // head word stays put until it transfers.
    assign count     = wr_ptr - rd_ptr;
    assign full      = (count == PW'(DEPTH));
    assign empty     = (count == '0);
    assign rsp_valid = !empty;
    assign rsp_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign pop       = rsp_valid && rsp_ready;
    assign state     = state_q;

    always_comb begin
        state_d     = state_q;
        ack_d       = ack;
        proto_err_d = proto_err;
        hold_d      = hold_q;
        dly_d       = dly_q;
        push        = 1'b0;
        case (state_q)
            S_IDLE: begin
                ack_d = 1'b0;
                if (req) begin
                    hold_d  = req_data;
                    dly_d   = 2'd1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                ack_d = 1'b0;
                if (!req) begin
                    proto_err_d = 1'b1;
                    hold_d      = '0;
                    state_d     = S_IDLE;
                end else if (dly_q < 2'(ACK_DELAY)) begin
                    dly_d = dly_q + 2'd1;
                // A pop on the same edge frees the slot the push needs.
                end else if (!full || pop) begin
                    push    = 1'b1;
                    ack_d   = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                ack_d = req;
                if (!req) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ack       <= 1'b0;
            proto_err <= 1'b0;
            hold_q    <= '0;
            dly_q     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            state_q   <= state_d;
            ack       <= ack_d;
            proto_err <= proto_err_d;
            hold_q    <= hold_d;
            dly_q     <= dly_d;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= hold_q;
        end
    end

endmodule

// File: tb/tb_req_ack_responder.sv
// Bench for req_ack_responder: directed handshake scenarios plus randomized traffic,
// with a queue scoreboard checked by a monitor on the falling clock edge.
module tb_req_ack_responder;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst;
    logic              req, rsp_ready;
    logic [DATA_W-1:0] req_data;
    logic              ack, rsp_valid, full, empty, proto_err;
    logic [DATA_W-1:0] rsp_data;
    logic [CW-1:0]     count;
    logic [1:0]        state;

    logic              req_3, rsp_ready_3;
    logic [DATA_W-1:0] req_data_3;
    logic              ack_3, rsp_valid_3, full_3, empty_3, proto_err_3;
    logic [DATA_W-1:0] rsp_data_3;
    logic [CW-1:0]     count_3;
    logic [1:0]        state_3;

    int                n_checks = 0;
    int                n_fail   = 0;
    logic [DATA_W-1:0] exp_q[$];
    bit                rand_ready = 1'b0;
    bit                low_occ    = 1'b0;
    bit                exp_proto  = 1'b0;

    req_ack_responder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ACK_DELAY(1)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .count(count), .full(full), .empty(empty), .proto_err(proto_err), .state(state)
    );

    req_ack_responder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ACK_DELAY(3)) dut_3 (
        .clk(clk), .rst(rst), .req(req_3), .req_data(req_data_3), .ack(ack_3),
        .rsp_valid(rsp_valid_3), .rsp_data(rsp_data_3), .rsp_ready(rsp_ready_3),
        .count(count_3), .full(full_3), .empty(empty_3), .proto_err(proto_err_3),
        .state(state_3)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: pops one expected word per downstream transfer.
    always @(negedge clk) begin
        if (!rst) begin
            check("valid_vs_empty", 32'(rsp_valid), 32'(!empty));
            check("full_vs_count", 32'(full), 32'(int'(count) == DEPTH));
            check("empty_vs_count", 32'(empty), 32'(count == 0));
            check("count_le_depth", 32'(int'(count) <= DEPTH), 32'd1);
            check("state_legal", 32'(state != 2'b11), 32'd1);
            check("count_model", 32'((int'(count) == exp_q.size()) ||
                                     (int'(count) + 1 == exp_q.size())), 32'd1);
            if (empty) check("empty_data_zero", 32'(rsp_data), 32'd0);
            if (low_occ) begin
                check("b2b_count", 32'(count <= 1), 32'd1);
                check("b2b_full", 32'(full), 32'd0);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) check("pop_unexpected", 32'd1, 32'd0);
                else check("rsp_data", 32'(rsp_data), 32'(exp_q.pop_front()));
            end
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_txn(input logic [DATA_W-1:0] d, input int exp_lat);
        int n = 0;
        req      = 1'b1;
        req_data = d;
        exp_q.push_back(d);
        while (n < 200) begin
            step();
            n++;
            if (ack) break;
        end
        check("ack_rise", 32'(ack), 32'd1);
        if (exp_lat > 0) check("ack_latency", 32'(n), 32'(exp_lat));
        req      = 1'b0;
        req_data = 8'($urandom);
        step();
        check("ack_fall", 32'(ack), 32'd0);
        check("state_idle_after", 32'(state), 32'd0);
    endtask

    task automatic withdraw(input logic [DATA_W-1:0] d);
        req      = 1'b1;
        req_data = d;
        step();
        check("wd_state_wait", 32'(state), 32'd1);
        check("wd_ack_low", 32'(ack), 32'd0);
        req       = 1'b0;
        exp_proto = 1'b1;
        step();
        check("wd_proto_err", 32'(proto_err), 32'd1);
        check("wd_state_idle", 32'(state), 32'd0);
        check("wd_ack_low2", 32'(ack), 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            req_data = 8'($urandom);
            step();
        end
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (empty) break;
        end
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_exp_q", 32'(exp_q.size()), 32'd0);
        check("drain_valid", 32'(rsp_valid), 32'd0);
        check("drain_data", 32'(rsp_data), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; req = 1'b0; req_data = '0; rsp_ready = 1'b0;
        req_3 = 1'b0; req_data_3 = '0; rsp_ready_3 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_proto", 32'(proto_err), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_data", 32'(rsp_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single transaction, then drain it
        do_txn(8'hA5, 2);
        check("s1_valid", 32'(rsp_valid), 32'd1);
        check("s1_data", 32'(rsp_data), 32'hA5);
        check("s1_count", 32'(count), 32'd1);
        drain();
        rsp_ready = 1'b0;

        // Fill the FIFO, stall a fifth request, release with one pop
        for (int i = 1; i <= 4; i++) do_txn(8'(i), 2);
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd4);
        req = 1'b1; req_data = 8'h05;
        exp_q.push_back(8'h05);
        repeat (4) begin
            step();
            check("stall_state", 32'(state), 32'd1);
            check("stall_ack", 32'(ack), 32'd0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("pushpop_ack", 32'(ack), 32'd1);
        check("pushpop_count", 32'(count), 32'd4);
        check("pushpop_full", 32'(full), 32'd1);
        req = 1'b0;
        step();
        check("pushpop_ack_fall", 32'(ack), 32'd0);
        drain();

        // Protocol error on the fast responder, then randomized traffic
        withdraw(8'h77);
        rand_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            idle_cycles($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) withdraw(8'($urandom));
            else do_txn(8'($urandom), 0);
        end
        rand_ready = 1'b0;
        drain();
        check("rand_proto_sticky", 32'(proto_err), 32'(exp_proto));

        // Back-to-back with the consumer always ready
        low_occ = 1'b1;
        for (int i = 0; i < 10; i++) do_txn(8'(i), 2);
        low_occ = 1'b0;
        drain();
        rsp_ready = 1'b0;

        // ACK_DELAY=3 responder: early withdrawal, then one clean transaction
        req_3 = 1'b1; req_data_3 = 8'h5A;
        @(posedge clk); #1;
        check("d3_state_wait", 32'(state_3), 32'd1);
        check("d3_ack_low", 32'(ack_3), 32'd0);
        req_3 = 1'b0;
        @(posedge clk); #1;
        check("d3_proto", 32'(proto_err_3), 32'd1);
        check("d3_state_idle", 32'(state_3), 32'd0);
        check("d3_count", 32'(count_3), 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check("d3_proto_sticky", 32'(proto_err_3), 32'd1);
            check("d3_ack_never", 32'(ack_3), 32'd0);
        end
        req_3 = 1'b1; req_data_3 = 8'h3C;
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            if (ack_3) break;
        end
        check("d3_latency", 32'(n), 32'd4);
        check("d3_data", 32'(rsp_data_3), 32'h3C);
        check("d3_count1", 32'(count_3), 32'd1);
        req_3 = 1'b0;
        @(posedge clk); #1;
        check("d3_ack_fall", 32'(ack_3), 32'd0);

        // Asynchronous reset while in ACK with two words queued
        do_txn(8'h11, 2);
        req = 1'b1; req_data = 8'h22;
        exp_q.push_back(8'h22);
        n = 0;
        while (n < 20 && !ack) begin
            step();
            n++;
        end
        check("pre_rst_state", 32'(state), 32'd2);
        check("pre_rst_count", 32'(count), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("arst_ack", 32'(ack), 32'd0);
        check("arst_valid", 32'(rsp_valid), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_proto", 32'(proto_err), 32'd0);
        check("arst_state", 32'(state), 32'd0);
        check("arst_data", 32'(rsp_data), 32'd0);
        exp_q.delete();
        req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        do_txn(8'hA5, 2);
        check("post_rst_valid", 32'(rsp_valid), 32'd1);
        check("post_rst_data", 32'(rsp_data), 32'hA5);
        check("post_rst_count", 32'(count), 32'd1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/req_ack_responder.md
Name: req_ack_responder

Overview:
- Responder end of the 4-phase req/ack handshake driven by the DUT's controller FSM.
- Samples `req` together with a data word and raises `ack` after a programmable delay.
- Buffers each accepted word in a small FIFO and presents it downstream on a valid/ready port.
- Exposes `state`, `count`, `full`, `empty` and a sticky protocol error so formal-bench assertions can reach them.

Parameters:
- DATA_W, 8, width of request/response data.
- DEPTH, 4, response FIFO entries; power of two, >= 2.
- ACK_DELAY, 1, clock edges spent in WAIT before ack may rise; legal range 1..3.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  request level from initiator; 4-phase protocol.
- req_data  in  DATA_W  data qualified by req; captured at the accepting edge.
- ack  out  1  registered acknowledge.
- rsp_valid  out  1  FIFO non-empty.
- rsp_data  out  DATA_W  FIFO head; 0 when empty.
- rsp_ready  in  1  downstream pop; pop occurs when rsp_valid && rsp_ready at posedge.
- count  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- proto_err  out  1  sticky; set on req withdrawn before ack.
- state  out  2  FSM state, for assertions.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE (2'b00), ack = 0, proto_err = 0, hold register = 0, delay counter = 0.
  - Pointers = 0, so count = 0, empty = 1, full = 0, rsp_valid = 0, rsp_data = 0.
  - Reset mid-transaction discards the FIFO contents and any captured word.
- FSM encoding: IDLE 2'b00, WAIT 2'b01, ACK 2'b10. 2'b11 is illegal and returns to IDLE with ack = 0 on the next edge.
- IDLE: if req = 1 at an edge, capture req_data into the hold register, set delay counter = 1, go to WAIT. ack stays 0.
- WAIT:
  - If req = 0: set proto_err, discard the held word, go to IDLE. No push.
  - Else if delay counter < ACK_DELAY: increment the counter.
  - Else if there is space: push the held word, ack <= 1, go to ACK. Space means count < DEPTH, or count == DEPTH with a pop on the same edge.
  - Else (full, no pop): remain in WAIT with ack = 0. Stall is unbounded.
- ACK: ack held at 1 while req = 1. On the edge that samples req = 0: ack <= 0, go to IDLE.
- A new req is accepted only from IDLE, so at least one ack-low cycle separates transactions.
- Latency: first edge sampling req high is E0. With the FIFO not full, ack is high after edge E0+ACK_DELAY; with ACK_DELAY = 1 this is 2 cycles after req rises.
- FIFO:
  - Circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH)+1 bits; count = wr_ptr - rd_ptr (modulo).
  - The extra MSB distinguishes full from empty across wrap-around.
  - Push and pop on the same edge leave count unchanged, including when full.
  - Pop when empty is ignored. Strict FIFO order.
  - rsp_data and rsp_valid are combinational from registered pointers/memory.
  - While rsp_valid && !rsp_ready, rsp_data is stable into the next cycle.
- proto_err is cleared only by rst.
- count never exceeds DEPTH. full and empty are never both 1.

Test Plan:
- ACK_DELAY=1, reset released, req=1 with req_data=0xA5 sampled at E0 -> ack=1 after E0+1; rsp_valid=1, rsp_data=0xA5, count=1. Drop req -> ack=0 after the next edge, state=2'b00.
- rsp_ready=0, four transactions 0x01..0x04 -> full=1, count=4. Fifth req (0x05) -> state stays 2'b01, ack=0. Pulse rsp_ready one cycle -> 0x01 popped, 0x05 pushed on the same edge, ack=1, count stays 4.
- Continuing from the previous case with rsp_ready=1 -> rsp_data sequence 0x02, 0x03, 0x04, 0x05. Then empty=1, rsp_valid=0, rsp_data=0.
- ACK_DELAY=3, req high for one edge, then low while in WAIT -> proto_err=1 and stays 1, count=0, state=2'b00, ack never rises.
- rsp_ready=1, ten back-to-back transactions with data 0..9 -> output order 0..9; pointers wrap past DEPTH, count <= 1 throughout, full never set.
- rst asserted mid-cycle while in ACK with count=2 -> ack, rsp_valid, count and proto_err go to 0 and state to 2'b00 before the next clock edge; first post-reset req behaves as in the first scenario.
